cl_sde_img_sched: RTL
=====================

// Module: cl_sde_img_sched
// PURPOSE
//  Image-level scheduler between the SDE input AXI-S FIFO and the TNN core (no backpressure).
//  Launches an image only when the FIFO holds a whole image and in-flight credit is free.
//  Pulls IMG_BEATS 512b beats per image and unpacks each beat into WORDS_PER_BEAT words,
//  one word per cycle, on core_valid/core_data. Counts core results to retire images.
// PARAMETERS
//  IMG_BEATS       16  beats (512b) per image; >=1
//  WORDS_PER_BEAT  8   words driven to core per beat; >=2
//  WORD_W          64  core word width; WORDS_PER_BEAT*WORD_W == 512
//  MAX_INFLIGHT    4   max images started but not retired; >=1
//  RES_PER_IMG     1   core result pulses per image; >=1
// PORTS
//  clk             in   1        single clock
//  rst             in   1        synchronous, active-high reset
//  cfg_enable      in   1        1 = new images may start
//  in_img_rdy      in   1        input FIFO holds >= 1 full image (= !prog_empty)
//  in_valid        in   1        input FIFO beat valid
//  in_data         in   512      input FIFO beat data
//  in_ready        out  1        beat pop strobe to input FIFO
//  core_valid      out  1        word valid to core
//  core_data       out  WORD_W   word to core (LSW of beat first)
//  core_res_valid  in   1        one core result accepted downstream
//  sts_busy        out  1        state != IDLE or inflight != 0
//  sts_inflight    out  8        images in flight
//  sts_started     out  32       images started (wraps)
//  sts_done        out  32       images retired (wraps)
//  sts_err         out  1        sticky: result received with inflight == 0
// BEHAVIOUR
//  Reset (rst=1 at clk edge): state=IDLE; in_ready, core_valid, sts_* = 0; core_data = 0.
//   Reset mid-image abandons it; no flush of the FIFO is issued.
//  States: IDLE, LOAD, SHIFT. beat_cnt counts 0..IMG_BEATS-1; word_cnt counts 0..WORDS_PER_BEAT-1.
//  IDLE: if cfg_enable && in_img_rdy && inflight < MAX_INFLIGHT, then go to LOAD.
//   On that transition: beat_cnt=0, inflight+1, sts_started+1.
//  LOAD: in_ready=1 (combinational from state). On in_valid: shreg<=in_data, word_cnt<=0, go to SHIFT.
//   With no in_valid, stay in LOAD; core_valid=0 (bubble).
//  SHIFT: core_valid=1, core_data=shreg[WORD_W-1:0] (registered outputs).
//   Each cycle: shreg >>= WORD_W and word_cnt+1.
//  Last word (word_cnt==WORDS_PER_BEAT-1):
//   - if beat_cnt==IMG_BEATS-1: in_ready=0 and go to IDLE.
//   - else: in_ready=1 and beat_cnt+1. With in_valid, reload shreg and stay in SHIFT
//     (no bubble; steady state 1 word/cycle). Without in_valid, go to LOAD.
//  in_ready is never 1 in IDLE. Exactly IMG_BEATS pops per started image.
//  cfg_enable is sampled only in IDLE. Deasserting it mid-image completes the current image.
//  Retire: res_cnt counts core_res_valid pulses 0..RES_PER_IMG-1.
//   On wrap: inflight-1 and sts_done+1.
//  Start and retire in the same cycle: inflight unchanged; both counters increment.
//  core_res_valid with inflight==0: ignored (res_cnt unchanged) and sts_err<=1 (sticky until rst).
//  Counters wrap modulo 2^32 silently.
//  Latency: first core_valid occurs 2 cycles after the IDLE->LOAD edge when in_valid=1 in LOAD.
//  in_img_rdy dropping mid-image has no effect; only in_valid gates beats.
// TESTING
//  1 image, in_valid always 1, defaults -> 128 consecutive core_valid cycles; words = beats LSW-first;
//   16 pops; sts_started=1.
//  in_valid low for 3 cycles before beat 5 -> exactly 3 bubble cycles on core_valid;
//   data order is unchanged.
//  No core_res_valid, 6 images available -> 4 images start then stall in IDLE (sts_inflight=4).
//   One result pulse -> 5th image starts.
//  core_res_valid in the same cycle as an image start at inflight=2 -> inflight stays 2;
//   started and done each +1.
//  core_res_valid at inflight=0 -> sts_err=1, sts_done=0. Then rst -> sts_err=0.
//  rst asserted mid-SHIFT (beat 7) -> next cycle core_valid=0, in_ready=0, state IDLE;
//   the next image runs normally.

Source files
------------

// File: rtl/cl_sde_img_sched_if.sv
// Input-FIFO and core-side signals of the image scheduler.
// The master modport is the scheduler; the slave modport is the FIFO/core side.
interface cl_sde_img_sched_if #(
  parameter int WORD_W = 64
);
  logic              in_img_rdy;
  logic              in_valid;
  logic [511:0]      in_data;
  logic              in_ready;
  logic              core_valid;
  logic [WORD_W-1:0] core_data;
  logic              core_res_valid;

  modport master (
    input  in_img_rdy, in_valid, in_data, core_res_valid,
    output in_ready, core_valid, core_data
  );

  modport slave (
    output in_img_rdy, in_valid, in_data, core_res_valid,
    input  in_ready, core_valid, core_data
  );
endinterface

// File: rtl/cl_sde_img_sched.sv
// Image-level scheduler: pulls whole images of 512b beats from the input FIFO,
// serialises them to the core one word per cycle, and retires images on core results.
module cl_sde_img_sched #(
  parameter int IMG_BEATS      = 16,
  parameter int WORDS_PER_BEAT = 8,
  parameter int WORD_W         = 64,
  parameter int MAX_INFLIGHT   = 4,
  parameter int RES_PER_IMG    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_enable,
  cl_sde_img_sched_if.master   bus,
  output logic                 sts_busy,
  output logic [7:0]           sts_inflight,
  output logic [31:0]          sts_started,
  output logic [31:0]          sts_done,
  output logic                 sts_err
);

  localparam int BW = (IMG_BEATS > 1) ? $clog2(IMG_BEATS) : 1;
  localparam int WW = $clog2(WORDS_PER_BEAT);
  localparam int RW = (RES_PER_IMG > 1) ? $clog2(RES_PER_IMG) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_e;

  state_e            state_q, state_d;
  logic [BW-1:0]     beat_cnt_q, beat_cnt_d;
  logic [WW-1:0]     word_cnt_q, word_cnt_d;
  logic [511:0]      shreg_q, shreg_d;
  logic              core_valid_q, core_valid_d;
  logic [WORD_W-1:0] core_data_q, core_data_d;
  logic [7:0]        inflight_q, inflight_d;
  logic [31:0]       started_q, started_d;
  logic [31:0]       done_q, done_d;
  logic [RW-1:0]     res_cnt_q, res_cnt_d;
  logic              err_q, err_d;
  logic              in_ready_c;
  logic              start_c;
  logic              res_fire_c;
  logic              retire_c;

  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    word_cnt_d   = word_cnt_q;
    shreg_d      = shreg_q;
    core_valid_d = 1'b0;
    core_data_d  = core_data_q;
    in_ready_c   = 1'b0;
    start_c      = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_enable && bus.in_img_rdy && (inflight_q < 8'(MAX_INFLIGHT))) begin
          start_c    = 1'b1;
          beat_cnt_d = '0;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          shreg_d    = bus.in_data;
          word_cnt_d = '0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        core_valid_d = 1'b1;
        core_data_d  = shreg_q[WORD_W-1:0];
        shreg_d      = shreg_q >> WORD_W;
        word_cnt_d   = word_cnt_q + 1'b1;
        // On the last word, refill straight from the FIFO so beats stream back to back.
        if (word_cnt_q == WW'(WORDS_PER_BEAT - 1)) begin
          word_cnt_d = '0;
          if (beat_cnt_q == BW'(IMG_BEATS - 1)) begin
            state_d = IDLE;
          end else begin
            in_ready_c = 1'b1;
            beat_cnt_d = beat_cnt_q + 1'b1;
            if (bus.in_valid) begin
              shreg_d = bus.in_data;
            end else begin
              state_d = LOAD;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Results arriving with nothing in flight are dropped and flagged.
  always_comb begin
    res_fire_c = bus.core_res_valid && (inflight_q != 8'd0);
    retire_c   = res_fire_c && (res_cnt_q == RW'(RES_PER_IMG - 1));
    res_cnt_d  = res_cnt_q;
    if (res_fire_c) begin
      res_cnt_d = retire_c ? '0 : res_cnt_q + 1'b1;
    end
    inflight_d = inflight_q + {7'd0, start_c} - {7'd0, retire_c};
    started_d  = started_q + {31'd0, start_c};
    done_d     = done_q + {31'd0, retire_c};
    err_d      = err_q | (bus.core_res_valid && (inflight_q == 8'd0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      beat_cnt_q   <= '0;
      word_cnt_q   <= '0;
      shreg_q      <= '0;
      core_valid_q <= 1'b0;
      core_data_q  <= '0;
      inflight_q   <= '0;
      started_q    <= '0;
      done_q       <= '0;
      res_cnt_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      word_cnt_q   <= word_cnt_d;
      shreg_q      <= shreg_d;
      core_valid_q <= core_valid_d;
      core_data_q  <= core_data_d;
      inflight_q   <= inflight_d;
      started_q    <= started_d;
      done_q       <= done_d;
      res_cnt_q    <= res_cnt_d;
      err_q        <= err_d;
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.core_valid = core_valid_q;
  assign bus.core_data  = core_data_q;
  assign sts_busy       = (state_q != IDLE) || (inflight_q != 8'd0);
  assign sts_inflight   = inflight_q;
  assign sts_started    = started_q;
  assign sts_done       = done_q;
  assign sts_err        = err_q;

endmodule
